usr_param: RTL and testbench

//  Parametrised universal shift register with command handshake and multi-bit shift.
//  One accepted command loads, holds, shifts or rotates q by cmd_amt positions.

---
 rtl/usr_pkg.sv | 39 +++
 rtl/usr_step.sv | 34 +++
 rtl/usr_param.sv | 104 ++++++++++
 tb/tb_usr_param.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// usr_pkg: shared types for the universal shift register.
//   usr_mode_e  - command opcode (3 bits, 111 reserved)
//   usr_state_e - sequencing FSM state
//   mode_illegal / mode_is_shift - opcode classification helpers
// Config macro: USR_ROTATE_EN. When undefined, ROR/ROL are classified as illegal.
package usr_pkg;

  typedef enum logic [2:0] {
    USR_HOLD = 3'd0,
    USR_SHR  = 3'd1,
    USR_SHL  = 3'd2,
    USR_LOAD = 3'd3,
    USR_ASR  = 3'd4,
    USR_ROR  = 3'd5,
    USR_ROL  = 3'd6,
    USR_RSVD = 3'd7
  } usr_mode_e;

  typedef enum logic [0:0] {
    USR_IDLE = 1'b0,
    USR_BUSY = 1'b1
  } usr_state_e;

  // Opcodes that complete immediately with an illegal pulse and leave q alone.
  function automatic logic mode_illegal(usr_mode_e m);
`ifdef USR_ROTATE_EN
    return m == USR_RSVD;
`else
    return (m == USR_RSVD) || (m == USR_ROR) || (m == USR_ROL);
`endif
  endfunction

  // Opcodes that take cmd_amt single-bit steps (legality checked separately).
  function automatic logic mode_is_shift(usr_mode_e m);
    return (m == USR_SHR) || (m == USR_SHL) || (m == USR_ASR) ||
           (m == USR_ROR) || (m == USR_ROL);
  endfunction

endpackage

// File: rtl/usr_step.sv
// usr_step: combinational single-bit step of the shift register.
//   q          in  WIDTH  current register value
//   mode       in  3      step operation (usr_mode_e)
//   s_in_left  in  1      serial bit entering the LSB on SHL
//   s_in_right in  1      serial bit entering the MSB on SHR
//   q_next     out WIDTH  value after one step (q for non-shift modes)
// Config macro: USR_ROTATE_EN. When undefined, the rotate paths are not built.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  usr_mode_e        mode,
  input  logic             s_in_left,
  input  logic             s_in_right,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      USR_SHR: q_next = {s_in_right, q[WIDTH-1:1]};
      USR_SHL: q_next = {q[WIDTH-2:0], s_in_left};
      USR_ASR: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
      USR_ROR: q_next = {q[0], q[WIDTH-1:1]};
      USR_ROL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
`endif
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/usr_param.sv
// usr_param: parametrised universal shift register with command handshake.
// One accepted command loads, holds, shifts or rotates q by cmd_amt positions,
// one bit per clock, then pulses done (and illegal for reserved opcodes).
//   clk, rst_n   clock; synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake, ready only in IDLE
//   cmd_mode, cmd_amt, d_in  command fields, sampled on accept only
//   s_in_left/s_in_right     serial inputs, sampled on every step edge
//   q            register contents
//   busy         high while further steps remain
//   done/illegal registered one-cycle completion pulses
// Config macro: USR_ROTATE_EN enables ROR/ROL; otherwise they act as reserved.
module usr_param
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] d_in,
  input  logic             s_in_left,
  input  logic             s_in_right,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  usr_state_e       state;
  usr_mode_e        mode_in, mode_q, step_mode;
  logic [AMT_W-1:0] remaining, amt_clamp;
  logic [WIDTH-1:0] q_step;

  assign mode_in   = usr_mode_e'(cmd_mode);
  assign cmd_ready = (state == USR_IDLE);
  assign busy      = (state == USR_BUSY);

  // Counts beyond WIDTH would only repeat work (or clear q), so clamp.
  assign amt_clamp = (cmd_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : cmd_amt;

  // The first step happens on the accept edge using the live command mode;
  // later steps use the latched mode.
  assign step_mode = (state == USR_IDLE) ? mode_in : mode_q;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .q          (q),
    .mode       (step_mode),
    .s_in_left  (s_in_left),
    .s_in_right (s_in_right),
    .q_next     (q_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= USR_IDLE;
      q         <= '0;
      remaining <= '0;
      mode_q    <= USR_HOLD;
      done      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        USR_IDLE: begin
          if (cmd_valid) begin
            if (mode_illegal(mode_in)) begin
              done    <= 1'b1;
              illegal <= 1'b1;
            end else if (mode_in == USR_LOAD) begin
              q    <= d_in;
              done <= 1'b1;
            end else if (!mode_is_shift(mode_in) || amt_clamp == '0) begin
              done <= 1'b1;
            end else begin
              q      <= q_step;
              mode_q <= mode_in;
              if (amt_clamp == AMT_W'(1)) begin
                done <= 1'b1;
              end else begin
                state     <= USR_BUSY;
                remaining <= amt_clamp - AMT_W'(1);
              end
            end
          end
        end
        USR_BUSY: begin
          q         <= q_step;
          remaining <= remaining - AMT_W'(1);
          if (remaining == AMT_W'(1)) begin
            state <= USR_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= USR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usr_param.sv
// tb_usr_param: directed + randomised bench for usr_param (WIDTH=8).
// Reference model tracks q as an integer and applies each step arithmetically.
// Honours USR_ROTATE_EN the same way as the design build.
module tb_usr_param;

  localparam int W  = 8;
  localparam int AW = $clog2(W + 1);
`ifdef USR_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, cmd_valid, cmd_ready;
  logic [2:0]    cmd_mode;
  logic [AW-1:0] cmd_amt;
  logic [W-1:0]  d_in, q;
  logic          s_in_left, s_in_right, busy, done, illegal;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] mq;

  always #5 clk = ~clk;

  usr_param #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_amt    (cmd_amt),
    .d_in       (d_in),
    .s_in_left  (s_in_left),
    .s_in_right (s_in_right),
    .q          (q),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One step of each operation expressed with integer arithmetic.
  function automatic logic [W-1:0] ref_step(input logic [W-1:0] v, input int m,
                                             input bit sl, input bit sr);
    int x, half, full, r;
    x = int'(v); half = 1 << (W - 1); full = 1 << W;
    case (m)
      1:       r = x / 2 + (sr ? half : 0);
      2:       r = (x * 2) % full + (sl ? 1 : 0);
      4:       r = x / 2 + ((x >= half) ? half : 0);
      5:       r = x / 2 + (x % 2) * half;
      6:       r = (x * 2) % full + x / half;
      default: r = x;
    endcase
    return W'(r);
  endfunction

  // Issue one command at a negedge (DUT idle) and follow it to its done cycle.
  // sfix < 0 randomises serial inputs per step, else drives sfix[0] on both.
  task automatic do_cmd(input int mode, input int amt, input logic [W-1:0] d,
                        input bit hold_valid, input int sfix);
    bit rsvd, shift, sl, sr;
    int n, edges;
    rsvd  = (mode == 7) || (!ROT && (mode == 5 || mode == 6));
    shift = !rsvd && (mode == 1 || mode == 2 || mode == 4 || mode == 5 || mode == 6);
    n     = (amt > W) ? W : amt;
    edges = (shift && n > 0) ? n : 1;
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_mode = 3'(mode); cmd_amt = AW'(amt); d_in = d;
    for (int e = 1; e <= edges; e++) begin
      sl = (sfix < 0) ? 1'($urandom) : sfix[0];
      sr = (sfix < 0) ? 1'($urandom) : sfix[0];
      s_in_left = sl; s_in_right = sr;
      @(posedge clk);
      if (shift && n > 0) mq = ref_step(mq, mode, sl, sr);
      else if (mode == 3) mq = d;
      @(negedge clk);
      chk($sformatf("q_m%0d_a%0d_e%0d", mode, amt, e), q, mq);
      if (e < edges) begin
        chk("busy_mid", busy, 1);
        chk("done_mid", done, 0);
        chk("ready_mid", cmd_ready, 0);
      end else begin
        chk("busy_end", busy, 0);
        chk("done_end", done, 1);
        chk("illegal_end", illegal, rsvd);
        chk("ready_end", cmd_ready, 1);
      end
      if (e == edges || !hold_valid) cmd_valid = 1'b0;
      else begin cmd_mode = 3'd3; d_in = '0; end
    end
  endtask

  task automatic idle_cycle();
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_illegal", illegal, 0);
    chk("idle_busy", busy, 0);
    chk("idle_q", q, mq);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_amt = '0; d_in = '0;
    s_in_left = 1'b0; s_in_right = 1'b0; mq = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;

    // Reset after a load clears q and the pending done.
    do_cmd(3, 0, 8'hA5, 0, -1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; mq = '0;
    chk("rst2_q", q, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_done", done, 0);
    chk("rst2_ready", cmd_ready, 1);

    do_cmd(3, 5, 8'h96, 0, -1);
    chk("load_96", q, 8'h96);
    idle_cycle();

    // SHL by 3 with serial 1s; held LOAD during busy must be ignored.
    do_cmd(2, 3, 8'h00, 1, 1);
    chk("shl_b7", q, 8'hB7);
    idle_cycle();

    do_cmd(3, 0, 8'h90, 0, -1);
    do_cmd(4, 2, 8'h00, 0, -1);
    chk("asr_e4", q, 8'hE4);
    idle_cycle();

    do_cmd(3, 0, 8'h81, 0, -1);
    do_cmd(5, 15, 8'h00, 0, -1);
    chk("ror_81", q, 8'h81);
    chk("ror_illegal", illegal, ROT ? 0 : 1);
    idle_cycle();

    // Mid-operation reset on the third edge of an 8-step SHR.
    do_cmd(3, 0, 8'hFF, 0, -1);
    cmd_valid = 1'b1; cmd_mode = 3'd1; cmd_amt = AW'(8); s_in_right = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_q1", q, 8'h7F);
    @(posedge clk);
    @(negedge clk);
    chk("mid_q2", q, 8'h3F);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; mq = '0;
    chk("mid_rst_q", q, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    idle_cycle();

    do_cmd(7, 3, 8'h55, 0, -1);
    chk("rsvd_q", q, 0);
    idle_cycle();

    // Random commands, mostly back-to-back.
    repeat (80) begin
      do_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), W'($urandom),
             1'($urandom), -1);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
